// File: rtl/seq_detect_pkg.sv
// Shared types and default sizes for the serial pattern detectors.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam int unsigned DEF_MAX_LEN = 8;
    localparam int unsigned DEF_CNT_W   = 8;

endpackage

// File: rtl/seq_detect_param_if.sv
// Configuration, serial data and result signals of the parametrised detector.
interface seq_detect_param_if
    import seq_detect_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
);
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               enable;
    logic               datain;
    logic               dataout;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, enable, datain,
        input  dataout, match_count, cfg_err
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, enable, datain,
        output dataout, match_count, cfg_err
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Run-time configurable serial pattern detector with registered match pulse
// and saturating match counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input logic               clock,
    input logic               reset,
    seq_detect_param_if.slave bus
);

    state_t             state;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;

    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_next;
    logic [LEN_W:0]     fill_inc;
    logic               match;
    logic               hit;
    logic               len_legal;

    always_comb begin
        len_mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
    end

    assign hist_next = {hist_q[MAX_LEN-2:0], bus.datain};
    assign fill_inc  = {1'b0, fill_q} + (LEN_W + 1)'(1);
    assign fill_next = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    // fill_inc counts the bit being accepted this cycle
    assign match     = (fill_inc >= {1'b0, len_q}) &&
                       (((hist_next ^ pattern_q) & len_mask) == '0);
    assign hit       = (state == RUN) && !bus.cfg_load && bus.enable && match;
    assign len_legal = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            pattern_q   <= '0;
            len_q       <= '0;
            overlap_q   <= 1'b0;
            hist_q      <= '0;
            fill_q      <= '0;
            bus.dataout <= 1'b0;
            bus.cfg_err <= 1'b0;
        end else if (bus.cfg_load) begin
            pattern_q   <= bus.cfg_pattern;
            len_q       <= bus.cfg_len;
            overlap_q   <= bus.cfg_overlap;
            hist_q      <= '0;
            fill_q      <= '0;
            bus.dataout <= 1'b0;
            state       <= len_legal ? RUN : ERR;
            bus.cfg_err <= !len_legal;
        end else begin
            case (state)
                RUN: begin
                    if (bus.enable) begin
                        hist_q      <= hist_next;
                        fill_q      <= (match && !overlap_q) ? '0 : fill_next;
                        bus.dataout <= match;
                    end else begin
                        bus.dataout <= 1'b0;
                    end
                end
                default: bus.dataout <= 1'b0;
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_count (
        .clock (clock),
        .reset (reset),
        .inc   (hit),
        .clr   (bus.cfg_load),
        .count (bus.match_count)
    );

endmodule
